// File: rtl/proximity_motor_ctrl.sv
// proximity_motor_ctrl: debounced near/far sequencing of the motor enable and
// alarm, with a saturated intrusion depth and its 7-segment encoding.
module proximity_motor_ctrl #(
    parameter int unsigned SAFE_DIST  = 10,
    parameter int unsigned STABLE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [4:0] distance,
    output logic       motor_en,
    output logic       alarm,
    output logic [2:0] excess,
    output logic [6:0] seg,
    output logic [1:0] state
);

    localparam int unsigned DCNT_W = $clog2(STABLE_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);
    localparam int unsigned DIFF_W = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;
    localparam logic [1:0] ST_COOL = 2'd3;

    // filt_q = 1 means the filtered class is near
    logic [1:0]        state_q,    state_d;
    logic              filt_q,     filt_d;
    logic [DCNT_W-1:0] dcnt_q,     dcnt_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic [2:0]        excess_q,   excess_d;
    logic [6:0]        seg_q,      seg_d;
    logic              motor_en_q, motor_en_d;
    logic              alarm_q,    alarm_d;

    logic              sample_near;
    logic              flip;
    logic [DIFF_W-1:0] diff;

    // 7-segment {g,f,e,d,c,b,a} active-high encoding of a 0..7 digit
    function automatic logic [6:0] seg_enc(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'h3F;
            3'd1:    s = 7'h06;
            3'd2:    s = 7'h5B;
            3'd3:    s = 7'h4F;
            3'd4:    s = 7'h66;
            3'd5:    s = 7'h6D;
            3'd6:    s = 7'h7D;
            default: s = 7'h07;
        endcase
        return s;
    endfunction

    // Sample classification, excess computation and debounce filter
    always_comb begin
        sample_near = ({1'b0, distance} < DIFF_W'(SAFE_DIST));
        diff        = DIFF_W'(SAFE_DIST) - DIFF_W'(distance);
        excess_d    = excess_q;
        filt_d      = filt_q;
        dcnt_d      = dcnt_q;
        flip        = 1'b0;
        if (sample_valid) begin
            if (sample_near) begin
                excess_d = (diff > DIFF_W'(7)) ? 3'd7 : diff[2:0];
            end else begin
                excess_d = 3'd0;
            end
            if (sample_near == filt_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DCNT_W'(STABLE_CYC - 1)) begin
                flip   = 1'b1;
                filt_d = sample_near;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + DCNT_W'(1);
            end
        end
        seg_d = seg_enc(excess_d);
    end

    // Next-state logic and registered output decode
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (flip && !filt_d) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flip && filt_d) state_d = ST_STOP;
            end
            ST_STOP: begin
                if (flip && !filt_d) begin
                    state_d = ST_COOL;
                    hold_d  = HOLD_W'(HOLD_CYC - 1);
                end
            end
            default: begin
                if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
                // a near flip beats an expiring hold on the same edge
                if (flip && filt_d) begin
                    state_d = ST_STOP;
                end else if (hold_q == '0) begin
                    state_d = ST_RUN;
                end
            end
        endcase
        motor_en_d = (state_d == ST_RUN);
        alarm_d    = (state_d == ST_STOP);
    end

    // State and datapath registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            filt_q     <= 1'b1;
            dcnt_q     <= '0;
            hold_q     <= '0;
            excess_q   <= 3'd0;
            seg_q      <= 7'h3F;
            motor_en_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            filt_q     <= filt_d;
            dcnt_q     <= dcnt_d;
            hold_q     <= hold_d;
            excess_q   <= excess_d;
            seg_q      <= seg_d;
            motor_en_q <= motor_en_d;
            alarm_q    <= alarm_d;
        end
    end

    assign motor_en = motor_en_q;
    assign alarm    = alarm_q;
    assign excess   = excess_q;
    assign seg      = seg_q;
    assign state    = state_q;

endmodule

// File: tb/tb_proximity_motor_ctrl.sv
// Scoreboard bench for proximity_motor_ctrl: the driver queues hand-computed
// expected outputs, a negedge monitor pops and compares them.
module tb_proximity_motor_ctrl;

    logic       clk;
    logic       rst;
    logic       sample_valid;
    logic [4:0] distance;
    logic       motor_en;
    logic       alarm;
    logic [2:0] excess;
    logic [6:0] seg;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic       m;
        logic       a;
        logic [2:0] ex;
        logic [6:0] sg;
    } exp_t;

    exp_t exp_q[$];

    proximity_motor_ctrl #(
        .SAFE_DIST (10),
        .STABLE_CYC(4),
        .HOLD_CYC  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_valid(sample_valid),
        .distance    (distance),
        .motor_en    (motor_en),
        .alarm       (alarm),
        .excess      (excess),
        .seg         (seg),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare every queued expectation at the falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks += 5;
            if (state !== e.st) begin
                n_fail++;
                $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
            end
            if (motor_en !== e.m) begin
                n_fail++;
                $display("FAIL %s motor_en: got %0b want %0b", e.name, motor_en, e.m);
            end
            if (alarm !== e.a) begin
                n_fail++;
                $display("FAIL %s alarm: got %0b want %0b", e.name, alarm, e.a);
            end
            if (excess !== e.ex) begin
                n_fail++;
                $display("FAIL %s excess: got %0d want %0d", e.name, excess, e.ex);
            end
            if (seg !== e.sg) begin
                n_fail++;
                $display("FAIL %s seg: got %h want %h", e.name, seg, e.sg);
            end
        end
    end

    task automatic expect_out(input string name, input logic [1:0] st, input logic m,
                              input logic a, input logic [2:0] ex, input logic [6:0] sg);
        exp_t e;
        e.name = name; e.st = st; e.m = m; e.a = a; e.ex = ex; e.sg = sg;
        exp_q.push_back(e);
    endtask

    // One accepted sample; returns 1 time unit after the capturing edge
    task automatic smp(input logic [4:0] d);
        sample_valid = 1'b1;
        distance     = d;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic smp_n(input logic [4:0] d, input int n);
        for (int i = 0; i < n; i++) smp(d);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        distance     = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 2'd0, 1'b0, 1'b0, 3'd0, 7'h3F);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // far samples: IDLE -> RUN exactly on the 4th
        smp_n(5'd20, 3);
        expect_out("far3_idle", 2'd0, 1'b0, 1'b0, 3'd0, 7'h3F);
        smp(5'd20);
        expect_out("far4_run", 2'd1, 1'b1, 1'b0, 3'd0, 7'h3F);

        // near samples distance 6: RUN -> STOP on the 4th, excess 4
        smp_n(5'd6, 3);
        expect_out("near3_run", 2'd1, 1'b1, 1'b0, 3'd4, 7'h66);
        smp(5'd6);
        expect_out("near4_stop", 2'd2, 1'b0, 1'b1, 3'd4, 7'h66);
        smp(5'd0);
        expect_out("sat_d0", 2'd2, 1'b0, 1'b1, 3'd7, 7'h07);
        smp(5'd9);
        expect_out("d9_ex1", 2'd2, 1'b0, 1'b1, 3'd1, 7'h06);

        // cooldown: STOP -> COOL, then RUN 8 cycles later
        smp_n(5'd15, 4);
        expect_out("cool_enter", 2'd3, 1'b0, 1'b0, 3'd0, 7'h3F);
        idle(7);
        expect_out("cool_7", 2'd3, 1'b0, 1'b0, 3'd0, 7'h3F);
        idle(1);
        expect_out("cool_run", 2'd1, 1'b1, 1'b0, 3'd0, 7'h3F);

        // glitch rejection in RUN
        smp_n(5'd6, 3);
        smp(5'd20);
        expect_out("glitch_far", 2'd1, 1'b1, 1'b0, 3'd0, 7'h3F);
        smp_n(5'd6, 3);
        expect_out("glitch_end", 2'd1, 1'b1, 1'b0, 3'd4, 7'h66);

        // valid gating: 20 cycles of distance 0 without valid
        distance = 5'd0;
        idle(20);
        expect_out("gated", 2'd1, 1'b1, 1'b0, 3'd4, 7'h66);

        // debounce count (3) survived the gap: one more near sample flips
        smp(5'd5);
        expect_out("resume_stop", 2'd2, 1'b0, 1'b1, 3'd5, 7'h6D);

        // near flip during COOL returns to STOP
        smp_n(5'd15, 4);
        idle(3);
        smp_n(5'd3, 3);
        expect_out("cool_near3", 2'd3, 1'b0, 1'b0, 3'd7, 7'h07);
        smp(5'd3);
        expect_out("cool_stop", 2'd2, 1'b0, 1'b1, 3'd7, 7'h07);

        // hold expiring on the same edge as a near flip: STOP wins
        smp_n(5'd15, 4);
        idle(4);
        smp_n(5'd8, 4);
        expect_out("tie_stop", 2'd2, 1'b0, 1'b1, 3'd2, 7'h5B);

        // asynchronous reset mid-COOL, checked before the next clk edge
        smp_n(5'd15, 4);
        idle(2);
        expect_out("pre_rst", 2'd3, 1'b0, 1'b0, 3'd0, 7'h3F);
        smp(5'd4);
        #1;
        rst = 1'b1;
        expect_out("async_rst", 2'd0, 1'b0, 1'b0, 3'd0, 7'h3F);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        smp_n(5'd20, 4);
        expect_out("post_rst_run", 2'd1, 1'b1, 1'b0, 3'd0, 7'h3F);

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/proximity_motor_ctrl.md
# proximity_motor_ctrl

Sequencing controller for the distance/motor datapath. It accepts distance samples from the sensor front end and debounces the near/far classification. A four-state FSM gates the motor enable, raises an alarm, and computes a saturated excess value with its 7-segment encoding for the display. It sits between the sensor sampler and the motor driver/display, replacing free-running combinational decisions with a hold-off-protected sequence.

## Interface
- SAFE_DIST, 10: distance threshold. A sample is "near" when distance < SAFE_DIST (unsigned).
- STABLE_CYC, 4: consecutive accepted samples of opposite class required to flip the filtered class (≥1).
- HOLD_CYC, 8: COOLDOWN duration in clock cycles (≥1).

- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high. One clock domain, no other clocks.
- sample_valid  in  1  distance qualifies on a clk edge where this is high.
- distance  in  5  unsigned sensor distance.
- motor_en  out  1  motor drive enable. Reset 0.
- alarm  out  1  proximity alarm. Reset 0.
- excess  out  3  saturated intrusion depth. Reset 0.
- seg  out  7  active-high {g,f,e,d,c,b,a} encoding of excess. Reset 7'h3F ("0").
- state  out  2  FSM state: IDLE=0, RUN=1, STOP=2, COOL=3. Reset 0.

## Operation
- Accepted sample: sample_valid=1 at a rising clk edge. Non-accepted cycles change nothing except the COOL counter.
- Excess register: updated on every accepted sample.
  - near sample: excess = min(SAFE_DIST − distance, 7).
  - far sample: excess = 0.
  - Arithmetic uses width ≥6 before saturation.
- seg encodes the registered excess: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07.
- Filtered class `filt`: reset value is near.
  - Debounce counter `dcnt` resets to 0. An accepted sample of the same class as filt clears dcnt.
  - An accepted sample of the opposite class increments dcnt.
  - On the STABLE_CYC-th consecutive opposite sample, filt flips and dcnt clears on that same edge.
- FSM (state register; outputs decoded from it):
  - IDLE: motor_en=0, alarm=0. Goes to RUN on the edge where filt flips to far.
  - RUN: motor_en=1. Goes to STOP on the edge where filt flips to near.
  - STOP: motor_en=0, alarm=1. Goes to COOL on the edge where filt flips to far; hold counter loads HOLD_CYC−1.
  - COOL: motor_en=0, alarm=0.
    - Hold counter decrements every clock.
    - Filt flipping to near → STOP.
    - Otherwise, counter==0 → RUN.
- Simultaneous events: in COOL with counter==0 and a near flip on the same edge, STOP wins.
- IDLE is entered only via reset.
- Reset mid-operation: all registers (state, filt, dcnt, hold counter, excess) return to reset values immediately, without waiting for clk. Operation resumes from IDLE after deassertion.

## Timing
- excess/seg: valid one edge after the accepted sample (registered, latency 1).
- State change occurs on the same edge as the flipping sample. motor_en/alarm reflect the new state immediately after that edge, with no extra cycle.
- Minimum RUN→STOP latency: STABLE_CYC accepted samples. With back-to-back valids this is STABLE_CYC cycles.
- COOL→RUN: exactly HOLD_CYC cycles after entering COOL, absent a near flip.
- dcnt never exceeds STABLE_CYC−1. The hold counter does not wrap; it stays at 0 if the state is not left.
- No combinational path from distance/sample_valid to any output.

## Test plan
- Reset, then 4 back-to-back valid samples with distance=20: state 0→1 on the 4th edge, motor_en=1, alarm=0, excess=0, seg=3F.
- From RUN, 4 valid samples with distance=6: state=2 on the 4th edge, motor_en=0, alarm=1, excess=4, seg=66. Repeat with distance=0: excess=7 (saturated), seg=07.
- Glitch rejection: in RUN, samples 6,6,6,20,6,6,6: state stays 1 throughout, excess ends at 4.
- Cooldown: from STOP, 4 samples distance=15 → state=3. With no further valids, state=1 and motor_en=1 exactly 8 cycles later. Repeat, injecting 4 samples distance=3 during COOL: state→2, alarm=1, excess=7.
- Valid gating and reset: with sample_valid=0, distance=0 held for 20 cycles in RUN, nothing changes. Asserting rst asynchronously mid-COOL gives state=0, motor_en=0, alarm=0, excess=0, seg=3F before the next clk edge.
